// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Start/busy/done handshake, clock-enable stall, one iteration per enabled cycle.
module seq_multiplier_param #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_mode;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_result;

   logic                 w_last;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic [2*WIDTH-1:0]   w_ext_a;
   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   assign w_last   = (r_cnt == LAST);
   assign w_ext_a  = signed_op ? {{WIDTH{a[WIDTH-1]}}, a}
                               : {{WIDTH{1'b0}}, a};
   assign w_addend = r_mplier[0] ? r_mcand : '0;
   // Multiplier MSB carries negative weight in signed mode.
   assign w_acc_nxt = (w_last && r_mode) ? (r_acc - w_addend)
                                         : (r_acc + w_addend);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else if (en) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (start)  w_state_nxt = S_RUN;
         S_RUN:  if (w_last) w_state_nxt = S_IDLE;
         default:            w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      unique case (r_state)
         S_IDLE: w_busy_nxt = start;
         S_RUN: begin
            w_busy_nxt = !w_last;
            w_done_nxt = w_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_mode   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else if (en) begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_mcand  <= w_ext_a;
               r_mplier <= b;
               r_mode   <= signed_op;
               r_acc    <= '0;
               r_cnt    <= '0;
            end
         end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
               r_result <= w_acc_nxt;
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule
